// File: rtl/sequenciador_mul_div.sv
// Multi-cycle multiply/divide sequencer: reads two bank registers, runs a 32-step
// shift-add multiply or restoring divide, and commits HI/LO through LDMULDIV.
module sequenciador_mul_div #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] D0,
    input  logic [31:0] D1,
    output logic [4:0]  RL0,
    output logic [4:0]  RL1,
    output logic [7:0]  ctrl,
    output logic [31:0] esc0,
    output logic [31:0] esc1,
    output logic        busy,
    output logic        done,
    output logic        divzero
);

    localparam logic [7:0] CTRL_NONE     = 8'h00;
    localparam logic [7:0] CTRL_LDREG    = 8'h20;
    localparam logic [7:0] CTRL_LDMULDIV = 8'hC0;
    localparam logic [5:0] LAST_ITER     = 6'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPT, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic        qsign_q, qsign_d;
    logic        rsign_q, rsign_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [4:0]  rl0_q, rl0_d, rl1_q, rl1_d;
    logic [31:0] esc0_q, esc0_d, esc1_q, esc1_d;
    logic        busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // acc = {partial product high, remaining multiplier bits}
    function automatic logic [63:0] mul_step(input logic [63:0] acc, input logic [31:0] m);
        logic [32:0] s;
        s = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
        return {s, acc[31:1]};
    endfunction

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] d);
        logic [32:0] r;
        logic        ge;
        logic [31:0] rem;
        r   = {acc[63:32], acc[31]};
        ge  = (r >= {1'b0, d});
        rem = ge ? (r[31:0] - d) : r[31:0];
        return {rem, acc[30:0], ge};
    endfunction

    logic        accept, is_div, is_signed, a_neg, b_neg, div_by_zero, last_iter;
    logic [31:0] a_abs, b_abs, res_lo, res_hi;
    logic [63:0] acc_step, prod_fix;

    assign accept      = (state_q == S_IDLE) && start;
    assign is_div      = op_q[1];
    assign is_signed   = ~op_q[0];
    assign a_neg       = is_signed & D0[31];
    assign b_neg       = is_signed & D1[31];
    assign a_abs       = a_neg ? neg32(D0) : D0;
    assign b_abs       = b_neg ? neg32(D1) : D1;
    assign div_by_zero = is_div && (D1 == 32'd0);
    assign last_iter   = (cnt_q == LAST_ITER);
    assign acc_step    = is_div ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
    assign prod_fix    = qsign_q ? neg64(acc_step) : acc_step;
    assign res_lo      = is_div ? (qsign_q ? neg32(acc_step[31:0]) : acc_step[31:0])
                                : prod_fix[31:0];
    assign res_hi      = is_div ? (rsign_q ? neg32(acc_step[63:32]) : acc_step[63:32])
                                : prod_fix[63:32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= 2'd0;
            cnt_q     <= 6'd0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            ctrl_q    <= CTRL_NONE;
            rl0_q     <= 5'd0;
            rl1_q     <= 5'd0;
            esc0_q    <= 32'd0;
            esc1_q    <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            ctrl_q    <= ctrl_d;
            rl0_q     <= rl0_d;
            rl1_q     <= rl1_d;
            esc0_q    <= esc0_d;
            esc1_q    <= esc1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  state_d = S_CAPT;
            S_CAPT:  state_d = div_by_zero ? S_WRITE : S_CALC;
            S_CALC:  if (last_iter) state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        rl0_d     = rl0_q;
        rl1_d     = rl1_q;
        esc0_d    = esc0_q;
        esc1_d    = esc1_q;
        divzero_d = divzero_q;

        ctrl_d = (state_d == S_READ)  ? CTRL_LDREG :
                 (state_d == S_WRITE) ? CTRL_LDMULDIV : CTRL_NONE;
        busy_d = (state_d == S_READ) || (state_d == S_CAPT) ||
                 (state_d == S_CALC) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);

        if (accept) begin
            op_d      = op;
            rl0_d     = rs;
            rl1_d     = rt;
            divzero_d = 1'b0;
        end

        case (state_q)
            S_CAPT: begin
                qsign_d = a_neg ^ b_neg;
                rsign_d = a_neg;
                cnt_d   = 6'd0;
                opnd_d  = is_div ? b_abs : a_abs;
                acc_d   = {32'd0, is_div ? a_abs : b_abs};
                if (div_by_zero) begin
                    divzero_d = 1'b1;
                    esc0_d    = 32'hFFFF_FFFF;
                    esc1_d    = D0;
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 6'd1;
                if (last_iter) begin
                    esc0_d = res_lo;
                    esc1_d = res_hi;
                end
            end
            default: ;
        endcase
    end

    assign ctrl    = ctrl_q;
    assign RL0     = rl0_q;
    assign RL1     = rl1_q;
    assign esc0    = esc0_q;
    assign esc1    = esc1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = divzero_q;

endmodule

// File: tb/tb_sequenciador_mul_div.sv
// Bench for sequenciador_mul_div: a small register-bank model feeds operands and
// absorbs LDMULDIV writes, which are matched against a queue of expected results.
module tb_sequenciador_mul_div;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] D0 = '0, D1 = '0;
    logic [4:0]  RL0, RL1;
    logic [7:0]  ctrl;
    logic [31:0] esc0, esc1;
    logic        busy, done, divzero;

    always #5 clk = ~clk;

    sequenciador_mul_div #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .D0(D0), .D1(D1), .RL0(RL0), .RL1(RL1), .ctrl(ctrl),
        .esc0(esc0), .esc1(esc1), .busy(busy), .done(done), .divzero(divzero)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          wcyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        vecs[$];
    logic [31:0] bank [32];
    logic [31:0] hi_r = '0, lo_r = '0;
    int          cyc = 0;
    int          tests = 0, fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bank model: read ports load on LDREG, HI/LO written on the negedge of LDMULDIV.
    always @(posedge clk) begin
        if (ctrl == 8'h20) begin
            D0 <= bank[RL0];
            D1 <= bank[RL1];
        end
    end

    always @(negedge clk) begin
        if (ctrl == 8'hC0) begin
            hi_r <= esc1;
            lo_r <= esc0;
            if (sbq.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("esc0_lo", {32'd0, esc0}, {32'd0, mon_e.lo});
                chk("esc1_hi", {32'd0, esc1}, {32'd0, mon_e.hi});
                chk("write_cycle", 64'(cyc), 64'(mon_e.wcyc));
            end
        end
    end

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi, output logic dz);
        logic signed [63:0] sa, sb, p, q, r;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        dz = 1'b0;
        lo = '0;
        hi = '0;
        if (o[1] && b == 32'd0) begin
            dz = 1'b1;
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else begin
            case (o)
                2'd0: begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; end
                2'd1: begin up = {32'd0, a} * {32'd0, b}; lo = up[31:0]; hi = up[63:32]; end
                2'd2: begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
                default: begin lo = a / b; hi = a % b; end
            endcase
        end
    endfunction

    task automatic add_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.op = o;
        v.a  = a;
        v.b  = b;
        model(o, a, b, v.lo, v.hi, v.dz);
        vecs.push_back(v);
    endtask

    task automatic do_op(input vec_t v);
        int lat, n;
        bit seen;
        lat = v.dz ? 3 : 35;
        bank[1] = v.a;
        bank[2] = v.b;
        @(negedge clk);
        start = 1'b1; op = v.op; rs = 5'd1; rt = 5'd2;
        n = cyc;
        sbq.push_back('{v.lo, v.hi, n + lat});
        @(negedge clk);
        start = 1'b0;
        chk("read_ctrl", {56'd0, ctrl}, 64'h20);
        chk("read_busy", {63'd0, busy}, 64'd1);
        chk("read_idx", {54'd0, RL0, RL1}, {54'd0, 5'd1, 5'd2});
        chk("divzero_clear", {63'd0, divzero}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("done_cycle", 64'(cyc - n), 64'(lat + 1));
        chk("done_busy", {63'd0, busy}, 64'd0);
        chk("done_ctrl", {56'd0, ctrl}, 64'd0);
        chk("divzero", {63'd0, divzero}, {63'd0, v.dz});
        chk("bank_lo", {32'd0, lo_r}, {32'd0, v.lo});
        chk("bank_hi", {32'd0, hi_r}, {32'd0, v.hi});
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int n;
        bit seen;
        logic [31:0] hi0, lo0;

        vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{2'd3, 32'hFFFF_FFF9, 32'h0000_0003, 32'h5555_5553, 32'h0000_0000, 1'b0});
        vecs.push_back('{2'd3, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0064, 1'b1});
        vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0});
        add_model(2'd0, 32'h8000_0000, 32'h8000_0000);
        add_model(2'd0, 32'h1234_5678, 32'hFFFF_0000);
        add_model(2'd2, 32'h0000_0007, 32'hFFFF_FFFE);
        add_model(2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        add_model(2'd2, 32'hFFFF_FF00, 32'h0000_0000);
        add_model(2'd1, 32'h0000_0000, 32'hDEAD_BEEF);
        add_model(2'd3, 32'h0000_0005, 32'h0000_0007);
        add_model(2'd3, 32'hFFFF_FFFF, 32'h0000_0001);

        for (int i = 0; i < 32; i++) bank[i] = 32'd0;
        reset = 1'b0; start = 1'b0; op = 2'd0; rs = 5'd0; rt = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {56'd0, ctrl}, 64'd0);
        chk("rst_busy_done_dz", {61'd0, busy, done, divzero}, 64'd0);
        chk("rst_idx", {54'd0, RL0, RL1}, 64'd0);
        chk("rst_esc", {esc1, esc0}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

        // start while busy (cycle 10) and during done must both be ignored
        v = '{2'd1, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 32'h0000_0000, 1'b0};
        bank[1] = v.a; bank[2] = v.b; bank[3] = 32'd99; bank[4] = 32'd77;
        @(negedge clk);
        start = 1'b1; op = v.op; rs = 5'd1; rt = 5'd2;
        n = cyc;
        sbq.push_back('{v.lo, v.hi, n + 35});
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1; op = 2'd2; rs = 5'd3; rt = 5'd4;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_idx", {54'd0, RL0, RL1}, {54'd0, 5'd1, 5'd2});
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ign_done_cycle", 64'(cyc - n), 64'd36);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("ign_idle_busy", {63'd0, busy}, 64'd0);
        chk("ign_bank", {hi_r, lo_r}, {v.hi, v.lo});

        // reset mid-operation: no commit, bank untouched, fresh op completes
        hi0 = hi_r; lo0 = lo_r;
        bank[1] = 32'hFFFF_FFFF; bank[2] = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs = 5'd1; rt = 5'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_ctrl", {56'd0, ctrl}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_write", {hi_r, lo_r}, {hi0, lo0});
        chk("rst_idle", {62'd0, busy, done}, 64'd0);
        do_op(vecs[0]);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequenciador_mul_div.md
# sequenciador_mul_div

Multi-cycle multiply/divide sequencer that sits beside the register bank and drives its control word. On a request it reads two general registers through the bank's read ports. It then runs a 32-iteration shift-add multiply or restoring divide internally. It finishes by committing the result to HI/LO with the bank's LDMULDIV write command. It is the only block that issues LDMULDIV writes; the core stalls on `busy`.

## Interface
Parameters
- `ITER`, 32: iterations in CALC; equals operand width, fixed at 32.

Ports
- `clk`  in  1  single clock, shared with the register bank; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `rs`, `rt`  in  5 each  source register indices (dividend/multiplicand = rs).
- `D0`, `D1`  in  32 each  bank read data.
- `RL0`, `RL1`  out  5 each  bank read indices.
- `ctrl`  out  8  bank control word.
- `esc0`, `esc1`  out  32 each  bank write data (LO, HI).
- `busy`  out  1  high from the first cycle after start is accepted through WRITE.
- `done`  out  1  one-cycle pulse after commit.
- `divzero`  out  1  sticky flag; set by a divide with rt value 0, cleared when the next start is accepted.

## Operation
- All outputs are registered.
- Reset values: `ctrl`=0x00, `RL0`=`RL1`=0, `esc0`=`esc1`=0, `busy`=0, `done`=0, `divzero`=0, state IDLE.
- IDLE
  - `ctrl`=0x00.
  - `start`=1 latches `op`, `rs`, `rt` and goes to READ.
- READ (1 cycle)
  - `ctrl`=0x20 (LDREG, no write bits), `RL0`=rs, `RL1`=rt.
  - The bank loads `D0`/`D1` at the closing edge.
- CAPT (1 cycle)
  - `ctrl`=0x00; capture `D0`→A, `D1`→B at the closing edge.
  - Signed ops store |A| and |B| and record the result signs:
    - product/quotient sign = sign(A) XOR sign(B);
    - remainder sign = sign(A).
  - For a divide with B==0: set `divzero` and go directly to WRITE with LO=0xFFFFFFFF, HI=A (raw, unsigned).
  - Otherwise go to CALC with the 6-bit counter = 0.
- CALC (exactly 32 cycles, counter 0..31)
  - Multiply: 64-bit accumulator shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first; 33-bit partial remainder.
  - Leave CALC after counter==31.
  - Apply the sign fix-up, two's-complement negate in the 64-bit/32-bit domain:
    - MULT: negate the 64-bit product if its sign is set;
    - DIV: negate the quotient by the quotient sign and the remainder by the remainder sign.
  - LO = low word or quotient; HI = high word or remainder.
  - DIV 0x80000000 / 0xFFFFFFFF produces LO=0x80000000, HI=0; no flag.
- WRITE (1 cycle)
  - `ctrl`=0xC0 (LDMULDIV, bits[1:0]=00), `esc0`=LO, `esc1`=HI.
  - The bank writes on this cycle's negedge.
  - `ctrl`[1:0] is never 11; that would redirect the write to PTIME.
- DONE (1 cycle)
  - `done`=1, `busy`=0, `ctrl`=0x00, then IDLE.
  - `start` in DONE is ignored.
- `start` while `busy`: ignored, no queueing.
- Reset mid-operation: return to IDLE with `ctrl`=0x00 at once.
  - No partial HI/LO write. If reset falls inside WRITE before the negedge, the write is suppressed.
- `esc0`/`esc1` hold their last values outside WRITE. They are meaningful only while `ctrl`=0xC0.

## Timing
- Cycle 0 is the edge where `start` is sampled in IDLE.
- Normal op:
  - READ cycle 1, CAPT cycle 2, CALC cycles 3–34, WRITE cycle 35, `done` cycle 36.
  - Next `start` is accepted at the end of cycle 37 or later.
- Divide by zero: READ 1, CAPT 2, WRITE 3, `done` 4.
- `busy` is high cycles 1–35 (1–3 for divide by zero).
- HI/LO in the bank are valid from the negedge of the WRITE cycle.
- A core reading HI/LO (LDHI/LDLO) must wait for `done`.
- Counter width is 6 bits; no wrap is reachable.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF
  - -> `ctrl`=0xC0 in cycle 35 with `esc1`=0xFFFFFFFE, `esc0`=0x00000001;
  - `done` in cycle 36, `divzero`=0.
- MULT rs=0xFFFFFFFD (−3), rt=7
  - -> `esc1`=0xFFFFFFFF, `esc0`=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (−7), rt=2
  - -> `esc0`=0xFFFFFFFD, `esc1`=0xFFFFFFFF.
- DIVU rs=0xFFFFFFF9, rt=3
  - -> `esc0`=0x55555553, `esc1`=0x00000000.
- DIVU rs=0x64, rt=0
  - -> `ctrl`=0xC0 in cycle 3 with `esc0`=0xFFFFFFFF, `esc1`=0x00000064;
  - `divzero`=1 and `done` in cycle 4;
  - `divzero` clears on the next accepted start.
- Start MULTU, pulse `start` again in cycle 10, then assert `reset` low in cycle 20
  - -> second start ignored;
  - on reset `ctrl`=0x00, `busy`=0, no 0xC0 ever driven, bank HI/LO unchanged;
  - a fresh `start` after reset release completes normally at +36 cycles.
